// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers h/v raster counters from an incoming sync pair, checks them against the mode and reports lock.
// Counters describe the sample currently held in the input register, so video data needs one register of delay.
module vga_sync_receiver #(
  parameter logic HORIZONTAL_SYNC_POLARITY = 1'b0,
  parameter int TIME_HORIZONTAL_VIDEO = 640,
  parameter int TIME_HORIZONTAL_FRONT_PORCH = 16,
  parameter int TIME_HORIZONTAL_SYNC_PULSE = 96,
  parameter int TIME_HORIZONTAL_BACK_PORCH = 48,
  parameter logic VERTICAL_SYNC_POLARITY = 1'b0,
  parameter int TIME_VERTICAL_VIDEO = 480,
  parameter int TIME_VERTICAL_FRONT_PORCH = 10,
  parameter int TIME_VERTICAL_SYNC_PULSE = 2,
  parameter int TIME_VERTICAL_BACK_PORCH = 33,
  parameter int HORIZONTAL_COUNTER_WIDTH = 10,
  parameter int VERTICAL_COUNTER_WIDTH = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic h_sync_in,
  input  logic v_sync_in,
  output logic [HORIZONTAL_COUNTER_WIDTH-1:0] h_counter,
  output logic [VERTICAL_COUNTER_WIDTH-1:0] v_counter,
  output logic display_active,
  output logic frame_start,
  output logic locked,
  output logic sync_error
);
  localparam int HW = HORIZONTAL_COUNTER_WIDTH;
  localparam int VW = VERTICAL_COUNTER_WIDTH;
  localparam logic HP = HORIZONTAL_SYNC_POLARITY;
  localparam logic VP = VERTICAL_SYNC_POLARITY;
  localparam int H_SS_I = TIME_HORIZONTAL_VIDEO + TIME_HORIZONTAL_FRONT_PORCH;
  localparam int V_SS_I = TIME_VERTICAL_VIDEO + TIME_VERTICAL_FRONT_PORCH;
  localparam logic [HW-1:0] H_VID = HW'(TIME_HORIZONTAL_VIDEO);
  localparam logic [HW-1:0] H_SS = HW'(H_SS_I);
  localparam logic [HW-1:0] H_SS1 = HW'(H_SS_I + 1);
  localparam logic [HW-1:0] H_SE = HW'(H_SS_I + TIME_HORIZONTAL_SYNC_PULSE);
  localparam logic [HW-1:0] H_LAST = HW'(H_SS_I + TIME_HORIZONTAL_SYNC_PULSE + TIME_HORIZONTAL_BACK_PORCH - 1);
  localparam logic [VW-1:0] V_VID = VW'(TIME_VERTICAL_VIDEO);
  localparam logic [VW-1:0] V_SS = VW'(V_SS_I);
  localparam logic [VW-1:0] V_SE = VW'(V_SS_I + TIME_VERTICAL_SYNC_PULSE);
  localparam logic [VW-1:0] V_LAST = VW'(V_SS_I + TIME_VERTICAL_SYNC_PULSE + TIME_VERTICAL_BACK_PORCH - 1);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t state_q;
  logic s_h_q, s_h_dly_q, s_v_q, s_v_dly_q;
  logic h_seen_q, err_q;
  logic [3:0] good_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic search, h_edge, v_edge, h_wrap, v_wrap, exp_h, exp_v, mismatch;

  always_comb begin
    search = state_q == SEARCH;
    h_edge = s_h_q == HP && s_h_dly_q != HP;
    v_edge = s_v_q == VP && s_v_dly_q != VP;
    h_wrap = h_q == H_LAST;
    v_wrap = v_q == V_LAST;
    exp_h = (h_q >= H_SS && h_q < H_SE) ? HP : ~HP;
    exp_v = (v_q >= V_SS && v_q < V_SE) ? VP : ~VP;
    mismatch = s_h_q != exp_h || s_v_q != exp_v;
    h_d = (search && h_edge) ? H_SS1 : h_wrap ? '0 : h_q + 1'b1;
    // an h_edge reload replaces the wrap, so the line count only advances on a genuine wrap
    v_d = (search && v_edge) ? V_SS : (h_wrap && !(search && h_edge)) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_h_q <= ~HP;
      s_h_dly_q <= ~HP;
      s_v_q <= ~VP;
      s_v_dly_q <= ~VP;
      h_q <= '0;
      v_q <= '0;
      state_q <= SEARCH;
      h_seen_q <= 1'b0;
      good_q <= '0;
      err_q <= 1'b0;
    end else begin
      s_h_q <= h_sync_in;
      s_h_dly_q <= s_h_q;
      s_v_q <= v_sync_in;
      s_v_dly_q <= s_v_q;
      h_q <= h_d;
      v_q <= v_d;
      err_q <= 1'b0;
      if (search) begin
        if (h_edge) h_seen_q <= 1'b1;
        if (v_edge && h_seen_q && h_q == '0) begin
          state_q <= ACQUIRE;
          good_q <= '0;
        end
      end else if (mismatch) begin
        err_q <= 1'b1;
        state_q <= SEARCH;
        h_seen_q <= 1'b0;
        good_q <= '0;
      end else if (state_q == ACQUIRE && h_wrap && v_wrap) begin
        good_q <= good_q + 4'd1;
        if (good_q + 4'd1 == LF) state_q <= LOCKED;
      end
    end
  end

  assign h_counter = h_q;
  assign v_counter = v_q;
  assign locked = state_q == LOCKED;
  assign display_active = locked && h_q < H_VID && v_q < V_VID;
  assign frame_start = locked && h_q == '0 && v_q == '0;
  assign sync_error = err_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed bench on a 16x9 raster (8/2/3/3, 4/1/2/2), frame = 144 clocks.
// Sync starts: h=10..12 active, v lines 5..6 active, both active-low.
module tb_vga_sync_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic h_sync_in = 1'b1;
  logic v_sync_in = 1'b1;
  logic [5:0] h_counter;
  logic [4:0] v_counter;
  logic display_active, frame_start, locked, sync_error;

  int checks = 0, errors = 0;
  int gh = 0, gv = 0, ph = 0, pv = 0, htot = 16;
  bit inv_h = 1'b0, inj_v = 1'b0;
  int lock_t, drop_t, se_t, da, fs, se, lk;

  vga_sync_receiver #(
    .HORIZONTAL_SYNC_POLARITY(1'b0),
    .TIME_HORIZONTAL_VIDEO(8),
    .TIME_HORIZONTAL_FRONT_PORCH(2),
    .TIME_HORIZONTAL_SYNC_PULSE(3),
    .TIME_HORIZONTAL_BACK_PORCH(3),
    .VERTICAL_SYNC_POLARITY(1'b0),
    .TIME_VERTICAL_VIDEO(4),
    .TIME_VERTICAL_FRONT_PORCH(1),
    .TIME_VERTICAL_SYNC_PULSE(2),
    .TIME_VERTICAL_BACK_PORCH(2),
    .HORIZONTAL_COUNTER_WIDTH(6),
    .VERTICAL_COUNTER_WIDTH(5),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in),
    .h_counter(h_counter),
    .v_counter(v_counter),
    .display_active(display_active),
    .frame_start(frame_start),
    .locked(locked),
    .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_h"}, int'(h_counter), 0);
    check({tag, "_v"}, int'(v_counter), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_display"}, int'(display_active), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_serr"}, int'(sync_error), 0);
  endtask

  // source model: drives sample (gh,gv), remembers it in (ph,pv), then advances
  task automatic gen();
    h_sync_in = ((gh >= 10 && gh < 13) ? 1'b0 : 1'b1) ^ inv_h;
    v_sync_in = (inj_v || (gv >= 5 && gv < 7)) ? 1'b0 : 1'b1;
    ph = gh;
    pv = gv;
    if (gh == htot - 1) begin
      gh = 0;
      gv = (gv == 8) ? 0 : gv + 1;
    end else gh++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    lock_t = -1; da = 0; fs = 0; se = 0;
    for (int t = 0; t < 720; t++) begin
      gen();
      @(negedge clk);
      if (locked && lock_t < 0) lock_t = t;
      if (t == 288) check("first_frame_start", int'(frame_start), 1);
      se += int'(sync_error);
      if (t >= 288) begin
        check("h_track", int'(h_counter), ph);
        check("v_track", int'(v_counter), pv);
        da += int'(display_active);
        fs += int'(frame_start);
      end
    end
    check("lock_time", lock_t, 288);
    check("display_cycles_3frames", da, 96);
    check("frame_start_3frames", fs, 3);
    check("sync_error_clean", se, 0);

    lock_t = -1; drop_t = -1; se_t = -1; se = 0;
    for (int r = 0; r < 340; r++) begin
      inv_h = (r == 37);
      gen();
      inv_h = 1'b0;
      @(negedge clk);
      if (sync_error) begin
        se++;
        if (se_t < 0) se_t = r;
      end
      if (!locked && drop_t < 0) drop_t = r;
      if (drop_t >= 0 && locked && lock_t < 0) lock_t = r;
    end
    check("inject_serr_time", se_t, 38);
    check("inject_drop_time", drop_t, 38);
    check("inject_serr_count", se, 1);
    check("relock_time", lock_t, 288);
    check("pre_reset_display", int'(display_active), 1);

    #2 reset = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    gh = 0; gv = 0; se = 0; lk = 0;
    for (int t = 0; t < 120; t++) begin
      inj_v = (gv == 1 && gh >= 7);
      gen();
      inj_v = 1'b0;
      @(negedge clk);
      se += int'(sync_error);
      lk += int'(locked);
      if (t == 24) check("vinject_v_load", int'(v_counter), 5);
    end
    check("vinject_serr", se, 0);
    check("vinject_locked", lk, 0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    htot = 15; gh = 0; gv = 0; lk = 0;
    for (int t = 0; t < 900; t++) begin
      gen();
      @(negedge clk);
      lk += int'(locked);
    end
    check("short_line_never_locks", lk, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Recovers raster timing from an incoming VGA h_sync/v_sync pair sampled in the pixel clock domain. It regenerates the pixel and line counters, verifies the incoming stream against the configured mode, and reports lock. It is the sink-side counterpart of the team's VGA timing generator and sits in front of capture or scaler logic that needs pixel coordinates for an external video source.

## Interface
- HORIZONTAL_SYNC_POLARITY, 1'b0, active level of h_sync_in
- TIME_HORIZONTAL_VIDEO / _FRONT_PORCH / _SYNC_PULSE / _BACK_PORCH, 640/16/96/48, horizontal mode
- VERTICAL_SYNC_POLARITY, 1'b0, active level of v_sync_in
- TIME_VERTICAL_VIDEO / _FRONT_PORCH / _SYNC_PULSE / _BACK_PORCH, 480/10/2/33, vertical mode
- HORIZONTAL_COUNTER_WIDTH, 10; VERTICAL_COUNTER_WIDTH, 10
- LOCK_FRAMES, 2, clean frame completions required for lock (1..15)
- Derived: H_TOTAL = sum of horizontal times (800); H_SYNC_START = VIDEO+FP (656); H_SYNC_END = H_SYNC_START+PULSE (752). V_TOTAL, V_SYNC_START, V_SYNC_END are defined the same way (525/490/492).
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- h_sync_in  in  1  horizontal sync, synchronous to clk
- v_sync_in  in  1  vertical sync, synchronous to clk
- h_counter  out  HORIZONTAL_COUNTER_WIDTH  recovered pixel index of the current sample
- v_counter  out  VERTICAL_COUNTER_WIDTH  recovered line index
- display_active  out  1  current sample is in the visible area and the receiver is locked
- frame_start  out  1  one-cycle pulse at (0,0) while locked
- locked  out  1  state == LOCKED
- sync_error  out  1  one-cycle pulse on a sync mismatch in ACQUIRE or LOCKED

## Operation
- Input stage: h_sync_in and v_sync_in are registered once into s_h and s_v; s_h_d holds the previous s_h.
  - All counters refer to the sample currently held in s_h/s_v.
  - Video data must be delayed by one register to stay aligned.
- Edge detection: h_edge = s_h==POL && s_h_d!=POL. v_edge is defined the same way.
- Counters: h_counter increments and wraps from H_TOTAL-1 to 0. On each h wrap, v_counter increments and wraps from V_TOTAL-1 to 0.
- Expected syncs: exp_h = POL when H_SYNC_START <= h_counter < H_SYNC_END, else ~POL. exp_v is the same on v_counter.
- SEARCH (reset state):
  - On h_edge: h_counter <= H_SYNC_START+1, and h_seen is set.
  - On v_edge: v_counter <= V_SYNC_START. If h_seen is set and h_counter==0, go to ACQUIRE with good_frames=0; otherwise stay in SEARCH.
  - Mismatches are ignored; sync_error stays 0.
- ACQUIRE and LOCKED:
  - Counters run freely; edges are not used.
  - Each cycle, compare s_h against exp_h and s_v against exp_v. Any mismatch: sync_error <= 1, state <= SEARCH, h_seen <= 0, good_frames <= 0.
- ACQUIRE: on each counter wrap to (0,0) with no mismatch, good_frames increments. When it would reach LOCK_FRAMES, state <= LOCKED on that same edge.
- LOCKED: remains until a mismatch or reset.
- display_active = locked && h_counter < H_VIDEO && v_counter < V_VIDEO.
- frame_start = locked && h_counter==0 && v_counter==0.
- Simultaneous h_edge and v_edge in SEARCH: both loads occur. The h_counter==0 test uses the pre-load value.

## Timing
- Reset asserted: all outputs 0 immediately. Counters 0, state SEARCH, h_seen 0, good_frames 0. s_h, s_h_d, s_v, s_v_d reset to ~POL so no edge is detected after release.
- Input-to-counter latency: 1 cycle. When locked, h_counter equals the source's h_counter delayed by 1 clk.
- sync_error goes high the cycle after the mismatching sample is in s_h/s_v. locked falls in the same cycle.
- locked rises in the cycle the counters read (0,0) at the end of the LOCK_FRAMES-th clean frame. frame_start pulses in that same cycle.
- Reset released mid-frame: the receiver needs the next v_edge plus LOCK_FRAMES frames to lock.

## Test plan
- Source is the team's VGA generator (default 640x480), reset released at t0:
  - After the first v_edge, locked rises 28000+420000 cycles later.
  - From then on, h_counter and v_counter equal the generator counters delayed 1 cycle, every cycle.
- Locked, clean stream for 3 frames -> display_active high for exactly 307200 cycles per frame; frame_start once per 420000 cycles; sync_error never asserted.
- Locked, one-cycle inverted h_sync_in at generator h=100 -> sync_error high for 1 cycle, locked drops in that same cycle. Relock occurs at the second (0,0) wrap after the next valid v_edge.
- Locked, reset pulled low mid-line at h=300 -> all outputs 0 asynchronously. After release, state is SEARCH and there is no spurious sync_error.
- Generator with TIME_HORIZONTAL_BACK_PORCH=47 (799-cycle lines) -> locked never rises. sync_error pulses at least once per frame after each SEARCH->ACQUIRE entry.
- v_sync_in edge injected at h_counter=400 while in SEARCH -> no transition to ACQUIRE; v_counter loaded to 490.
